// File: rtl/datapath_unit.sv
// Execution datapath: 2R/1W register file, combinational ALU, 256x16 data RAM with registered read,
// write-back mux. Optional Z/C/V flag register is built when DATAPATH_FLAGS_EN is defined.
module datapath_unit #(
    parameter int DATA_W  = 16,
    parameter int RF_AW   = 4,
    parameter int DMEM_AW = 8
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic [DMEM_AW-1:0] Dmem_addr,
    input  logic               D_wr_en,
    input  logic               RF_sel,
    input  logic [RF_AW-1:0]   RF_wr_addr,
    input  logic               RF_wr_en,
    input  logic [RF_AW-1:0]   RF_RA_addr,
    input  logic [RF_AW-1:0]   RF_RB_addr,
    input  logic [2:0]         ALU_sel0,
    output logic [DATA_W-1:0]  RA_data,
    output logic [DATA_W-1:0]  RB_data,
    output logic [DATA_W-1:0]  ALU_out,
    output logic [DATA_W-1:0]  Mem_q,
    output logic [DATA_W-1:0]  W_data,
    output logic               Flag_Z,
    output logic               Flag_C,
    output logic               Flag_V
);

    localparam int RF_N   = 2 ** RF_AW;
    localparam int DMEM_N = 2 ** DMEM_AW;

    logic [DATA_W-1:0] rf  [RF_N];
    logic [DATA_W-1:0] mem [DMEM_N];

    // No write-through: a read of the register being written shows the old value until the edge.
    assign RA_data = rf[RF_RA_addr];
    assign RB_data = rf[RF_RB_addr];
    assign W_data  = RF_sel ? Mem_q : ALU_out;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < RF_N; i++) rf[i] <= '0;
        end else if (RF_wr_en) begin
            rf[RF_wr_addr] <= W_data;
        end
    end

    // RAM array carries no reset; the ResetN gate keeps an edge during reset from storing anything.
    always_ff @(posedge Clock) begin
        if (D_wr_en && ResetN) mem[Dmem_addr] <= RA_data;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) Mem_q <= '0;
        else         Mem_q <= mem[Dmem_addr];
    end

    always_comb begin
        ALU_out = '0;
        case (ALU_sel0)
            3'b000: ALU_out = '0;
            3'b001: ALU_out = RA_data + RB_data;
            3'b010: ALU_out = RA_data - RB_data;
            3'b011: ALU_out = RA_data;
            3'b100: ALU_out = RA_data ^ RB_data;
            3'b101: ALU_out = RA_data | RB_data;
            3'b110: ALU_out = RA_data & RB_data;
            default: ALU_out = RA_data + 1'b1;
        endcase
    end

`ifdef DATAPATH_FLAGS_EN
    logic [DATA_W:0] add_ext, sub_ext, inc_ext;
    logic            alu_c, alu_v;
    logic            sa, sb, sr;

    assign add_ext = {1'b0, RA_data} + {1'b0, RB_data};
    assign sub_ext = {1'b0, RA_data} - {1'b0, RB_data};
    assign inc_ext = {1'b0, RA_data} + 1'b1;
    assign sa      = RA_data[DATA_W-1];
    assign sb      = RB_data[DATA_W-1];
    assign sr      = ALU_out[DATA_W-1];

    // Carry is the add carry-out, or the borrow for subtract; V is signed overflow.
    always_comb begin
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (ALU_sel0)
            3'b001: begin
                alu_c = add_ext[DATA_W];
                alu_v = (sa == sb) && (sr != sa);
            end
            3'b010: begin
                alu_c = sub_ext[DATA_W];
                alu_v = (sa != sb) && (sr != sa);
            end
            3'b111: begin
                alu_c = inc_ext[DATA_W];
                alu_v = !sa && sr;
            end
            default: begin
                alu_c = 1'b0;
                alu_v = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Flag_Z <= 1'b0;
            Flag_C <= 1'b0;
            Flag_V <= 1'b0;
        end else if (RF_wr_en && !RF_sel) begin
            Flag_Z <= (ALU_out == '0);
            Flag_C <= alu_c;
            Flag_V <= alu_v;
        end
    end
`else
    assign Flag_Z = 1'b0;
    assign Flag_C = 1'b0;
    assign Flag_V = 1'b0;
`endif

endmodule
